// File: rtl/dbus_sram_responder.sv
// Memory end of the dbus request/response handshake: a word-addressed SRAM
// that accepts one request at a time and answers after LATENCY cycles.

package dbus_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       misaligned
);

    // state | meaning
    // IDLE  | ready; addr_ok follows dreq.valid combinationally
    // WAIT  | request latched, counting down to the response cycle
    // RESP  | one-cycle response; writes commit on the edge leaving RESP
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int         WORDS  = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t state, state_nxt;
    logic [3:0] count, count_nxt;

    logic [31:0] lat_addr;
    msize_t      lat_size;
    logic [3:0]  lat_strobe;
    logic [31:0] lat_data;

    logic [31:0] mem [0:WORDS-1];

    logic                 accept;
    logic                 enter_resp;
    logic                 from_idle;
    logic [31:0]          cur_addr;
    msize_t               cur_size;
    logic [3:0]           cur_strobe;
    logic                 cur_mis;
    logic                 lat_mis;
    logic [ADDR_BITS-1:0] rd_idx;
    logic [ADDR_BITS-1:0] wr_idx;
    logic                 unused_addr_hi;

    logic        data_ok_q;
    logic        mis_q;
    logic [31:0] data_q;

    assign accept     = (state == IDLE) && dreq.valid;
    assign enter_resp = (state_nxt == RESP);

    // With LATENCY==1 the response is prepared on the acceptance edge itself,
    // before the latch holds the request, so take the fields straight from dreq.
    assign from_idle  = (state == IDLE);
    assign cur_addr   = from_idle ? dreq.addr   : lat_addr;
    assign cur_size   = from_idle ? dreq.size   : lat_size;
    assign cur_strobe = from_idle ? dreq.strobe : lat_strobe;

    assign cur_mis = ((cur_size == MSIZE2) && cur_addr[0]) ||
                     ((cur_size == MSIZE4) && (cur_addr[1:0] != 2'b00));
    assign lat_mis = ((lat_size == MSIZE2) && lat_addr[0]) ||
                     ((lat_size == MSIZE4) && (lat_addr[1:0] != 2'b00));

    assign rd_idx = cur_addr[ADDR_BITS+1:2];
    assign wr_idx = lat_addr[ADDR_BITS+1:2];

    assign unused_addr_hi = ^{cur_addr[31:ADDR_BITS+2], lat_addr[31:ADDR_BITS+2]};

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (dreq.valid) begin
                    count_nxt = LAT_M1;
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                count_nxt = count - 4'd1;
                if (count == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr   <= 32'd0;
            lat_size   <= MSIZE1;
            lat_strobe <= 4'd0;
            lat_data   <= 32'd0;
        end else if (accept) begin
            lat_addr   <= dreq.addr;
            lat_size   <= dreq.size;
            lat_strobe <= dreq.strobe;
            lat_data   <= dreq.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_ok_q <= 1'b0;
            mis_q     <= 1'b0;
            data_q    <= 32'd0;
        end else begin
            data_ok_q <= enter_resp;
            mis_q     <= enter_resp && cur_mis;
            if (enter_resp && (cur_strobe == 4'd0) && !cur_mis) begin
                data_q <= mem[rd_idx];
            end else begin
                data_q <= 32'd0;
            end
        end
    end

    // Contents survive reset; a reset during WAIT/RESP leaves state in IDLE so
    // an uncommitted write never reaches the array.
    always_ff @(posedge clk) begin
        if ((state == RESP) && (lat_strobe != 4'd0) && !lat_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_strobe[i]) begin
                    mem[wr_idx][8*i +: 8] <= lat_data[8*i +: 8];
                end
            end
        end
    end

    assign dresp.addr_ok = accept;
    assign dresp.data_ok = data_ok_q;
    assign dresp.data    = data_q;
    assign misaligned    = mis_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three instances (LATENCY 1, 2, 15), each with its
// own driver, word-level memory model and a scoreboard monitor.

module tb_dbus_sram_responder;
    import dbus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    longint cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        bit          mis;
        longint      acc;
    } exp_t;

    function automatic void chk(input int lat, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL L%0d %s: got %h want %h", lat, name, act, exp);
        end
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input msize_t s);
        return ((s == MSIZE2) && a[0]) || ((s == MSIZE4) && (a[1:0] != 2'b00));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lat
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 15;

        dbus_req_t   dreq;
        dbus_resp_t  dresp;
        logic        mis;
        logic        rst;
        bit          done_g = 1'b0;
        exp_t        q[$];
        logic [31:0] model [1024];
        bit          known [1024];
        longint      last_acc = 0;

        dbus_sram_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
            .clk       (clk),
            .reset     (rst),
            .dreq      (dreq),
            .dresp     (dresp),
            .misaligned(mis)
        );

        // mode 0: no acceptance timing check; 1: addr_ok on first cycle;
        // 2: back-to-back, acceptance exactly LAT+1 cycles after the previous one
        task automatic issue(input logic [31:0] a, input msize_t s, input logic [3:0] st,
                             input logic [31:0] d, input int mode, input bit use_lit,
                             input logic [31:0] lit, input bit track);
            int          n;
            bit          got;
            exp_t        e;
            logic [9:0]  idx;
            bit          m;
            n   = 0;
            got = 1'b0;
            dreq.valid  = 1'b1;
            dreq.addr   = a;
            dreq.size   = s;
            dreq.strobe = st;
            dreq.data   = d;
            while (!got && n < LAT + 4) begin
                @(negedge clk);
                if (dresp.addr_ok) got = 1'b1;
                else n++;
            end
            if (!got) begin
                tests++;
                fails++;
                $display("FAIL L%0d accept_timeout: got no addr_ok want addr_ok for addr %h", LAT, a);
                return;
            end
            if (mode == 1) chk(LAT, "addr_ok_first_cycle", 32'(n), 32'd0);
            if (mode == 2) chk(LAT, "accept_gap", 32'(cyc - last_acc), 32'(LAT + 1));
            last_acc = cyc;
            idx = a[11:2];
            m   = is_mis(a, s);
            e.mis = m;
            e.acc = cyc;
            if (st == 4'd0) begin
                e.data     = m ? 32'd0 : model[idx];
                e.chk_data = m || known[idx];
            end else begin
                e.data     = 32'd0;
                e.chk_data = 1'b1;
                if (track && !m) begin
                    for (int i = 0; i < 4; i++)
                        if (st[i]) model[idx][8*i +: 8] = d[8*i +: 8];
                    if (st == 4'hF) known[idx] = 1'b1;
                end
            end
            if (use_lit) begin
                e.data     = lit;
                e.chk_data = 1'b1;
            end
            if (track) q.push_back(e);
            @(posedge clk);
            #1;
        endtask

        task automatic drain();
            int k;
            k = 0;
            dreq.valid = 1'b0;
            while (q.size() != 0 && k < LAT + 6) begin
                @(posedge clk);
                k++;
            end
            #1;
            chk(LAT, "drain_pending", 32'(q.size()), 32'd0);
        endtask

        always @(negedge clk) begin
            exp_t e;
            if (!rst) begin
                if (dresp.data_ok) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL L%0d unexpected_data_ok: got data_ok=1 want 0", LAT);
                    end else begin
                        e = q.pop_front();
                        if (e.chk_data) chk(LAT, "resp_data", dresp.data, e.data);
                        chk(LAT, "misaligned", 32'(mis), 32'(e.mis));
                        chk(LAT, "latency", 32'(cyc - e.acc), 32'(LAT));
                    end
                end else begin
                    chk(LAT, "quiet_data", dresp.data, 32'd0);
                    chk(LAT, "quiet_misaligned", 32'(mis), 32'd0);
                end
            end
        end

        initial begin
            logic [31:0] a;
            logic [3:0]  st;
            dreq = '0;
            rst  = 1'b1;
            repeat (2) @(negedge clk);
            chk(LAT, "reset_addr_ok", 32'(dresp.addr_ok), 32'd0);
            chk(LAT, "reset_data_ok", 32'(dresp.data_ok), 32'd0);
            chk(LAT, "reset_data", dresp.data, 32'd0);
            chk(LAT, "reset_misaligned", 32'(mis), 32'd0);
            @(posedge clk);
            #1 rst = 1'b0;

            issue(32'h100, MSIZE4, 4'hF, 32'hDEADBEEF, 1, 1, 32'h0, 1);
            issue(32'h100, MSIZE4, 4'h0, 32'h0, 2, 1, 32'hDEADBEEF, 1);
            // byte-lane write: the byte sits in lane 1 of the data word
            issue(32'h101, MSIZE1, 4'b0010, 32'h0000AA00, 2, 1, 32'h0, 1);
            issue(32'h100, MSIZE4, 4'h0, 32'h0, 2, 1, 32'hDEADAAEF, 1);
            issue(32'h102, MSIZE4, 4'h0, 32'h0, 2, 1, 32'h0, 1);
            issue(32'h102, MSIZE2, 4'h0, 32'h0, 2, 1, 32'hDEADAAEF, 1);
            issue(32'h103, MSIZE2, 4'hF, 32'hFFFFFFFF, 2, 1, 32'h0, 1);
            issue(32'h100, MSIZE4, 4'h0, 32'h0, 2, 1, 32'hDEADAAEF, 1);
            issue(32'h40, MSIZE4, 4'hF, 32'hCAFEF00D, 2, 1, 32'h0, 1);
            drain();

            // write abandoned by reset in WAIT (RESP when LAT==1)
            issue(32'h40, MSIZE4, 4'hF, 32'h12345678, 1, 0, 32'h0, 0);
            dreq.valid = 1'b0;
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            issue(32'h40, MSIZE4, 4'h0, 32'h0, 1, 1, 32'hCAFEF00D, 1);

            for (int i = 0; i < 8; i++)
                issue(32'h200 + 32'(4 * i), MSIZE4, 4'hF, $urandom, 2, 0, 32'h0, 1);

            for (int i = 0; i < 30; i++) begin
                a  = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
                a  = a | (32'($urandom_range(0, 15)) << 12);
                st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                if ($urandom_range(0, 5) == 0) begin
                    dreq.valid = 1'b0;
                    repeat (LAT + $urandom_range(0, 2)) @(posedge clk);
                    #1;
                    issue(a, msize_t'($urandom_range(0, 2)), st, $urandom, 1, 0, 32'h0, 1);
                end else begin
                    issue(a, msize_t'($urandom_range(0, 2)), st, $urandom, 2, 0, 32'h0, 1);
                end
                if (LAT > 1) begin
                    dreq.addr = $urandom;
                    dreq.data = $urandom;
                end
            end
            drain();
            done_g = 1'b1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (!(lat[0].done_g && lat[1].done_g && lat[2].done_g) && k < 20000) begin
            @(posedge clk);
            k++;
        end
        if (!(lat[0].done_g && lat[1].done_g && lat[2].done_g)) begin
            tests++;
            fails++;
            $display("FAIL global_timeout: got unfinished drivers want all done");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
